sha256_msg_padder: RTL and testbench

- Upstream feeder for the SHA256 core. Accepts a raw message as a stream of 32-bit big-endian words with valid/ready flow control.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length.
- Emits 512-bit blocks on the msg[511:0] ordering the core expects: word 0 in bits 511:480.
- Flags the first and last block of each message so the core can load the IV and take the final digest.

---
 rtl/sha256_msg_padder.sv | 181 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// Pads a big-endian 32-bit word stream into 512-bit SHA-256 blocks.
// It appends the 0x80 marker, zero fill and the 64-bit bit length, and flags first/last blocks.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  localparam int CW = LEN_W - 3;

  typedef enum logic {ST_FILL, ST_EMIT} state_t;

  state_t      state_reg;
  logic [3:0]  w_reg;
  logic [CW-1:0] cnt_reg;
  logic        first_pending_reg;
  logic        in_ready_reg;
  logic        blk_valid_reg;
  logic        blk_first_reg;
  logic        blk_last_reg;
  logic        extra_pending_reg;
  logic        marker_in_extra_reg;

  logic        accept;
  logic        take;
  logic [2:0]  n_eff;
  logic [2:0]  n_add;
  logic [CW-1:0] cnt_acc;
  logic [LEN_W-1:0] bits_acc;
  logic [LEN_W-1:0] bits_cur;
  logic [63:0] len_acc;
  logic [63:0] len_cur;
  logic [4:0]  p_ext;
  logic        fits;
  logic [31:0] last_word;

  assign accept = (state_reg == ST_FILL) && in_ready_reg && in_valid;
  assign take   = (state_reg == ST_EMIT) && blk_valid_reg && blk_ready;

  // Out-of-range byte counts are treated as a full word.
  assign n_eff    = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign n_add    = in_last ? n_eff : 3'd4;
  assign cnt_acc  = cnt_reg + CW'(n_add);
  assign bits_acc = {cnt_acc, 3'b000};
  assign bits_cur = {cnt_reg, 3'b000};
  assign len_acc  = 64'(bits_acc);
  assign len_cur  = 64'(bits_cur);

  // Word index holding the 0x80 marker; 16 means it spills into the extra block.
  assign p_ext = {1'b0, w_reg} + ((n_eff == 3'd4) ? 5'd1 : 5'd0);
  assign fits  = (p_ext <= 5'd13);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      always_comb begin
        if (3'(gi) < n_eff)
          last_word[31-8*gi -: 8] = in_data[31-8*gi -: 8];
        else if (3'(gi) == n_eff)
          last_word[31-8*gi -: 8] = 8'h80;
        else
          last_word[31-8*gi -: 8] = 8'h00;
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      logic [31:0] word_reg;
      logic [31:0] word_next;

      always_comb begin
        word_next = word_reg;
        if (accept) begin
          if (w_reg == 4'(gi))
            word_next = in_last ? last_word : in_data;
          else if (in_last && (n_eff == 3'd4) && (p_ext == 5'(gi)))
            word_next = 32'h8000_0000;
          if (in_last && fits && (gi == 14))
            word_next = len_acc[63:32];
          if (in_last && fits && (gi == 15))
            word_next = len_acc[31:0];
        end else if (take) begin
          // Either build the trailing length-only block or clear for the next fill.
          word_next = 32'h0;
          if (extra_pending_reg) begin
            if (gi == 0)
              word_next = marker_in_extra_reg ? 32'h8000_0000 : 32'h0;
            if (gi == 14)
              word_next = len_cur[63:32];
            if (gi == 15)
              word_next = len_cur[31:0];
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (reset)
          word_reg <= 32'h0;
        else
          word_reg <= word_next;
      end

      assign blk_data[511-32*gi -: 32] = word_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg           <= ST_FILL;
      w_reg               <= 4'd0;
      cnt_reg             <= '0;
      first_pending_reg   <= 1'b1;
      in_ready_reg        <= 1'b0;
      blk_valid_reg       <= 1'b0;
      blk_first_reg       <= 1'b0;
      blk_last_reg        <= 1'b0;
      extra_pending_reg   <= 1'b0;
      marker_in_extra_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            cnt_reg <= cnt_acc;
            w_reg   <= w_reg + 4'd1;
            if (in_last || (w_reg == 4'd15)) begin
              state_reg           <= ST_EMIT;
              in_ready_reg        <= 1'b0;
              blk_valid_reg       <= 1'b1;
              blk_first_reg       <= first_pending_reg;
              w_reg               <= 4'd0;
              blk_last_reg        <= in_last && fits;
              extra_pending_reg   <= in_last && !fits;
              marker_in_extra_reg <= in_last && (p_ext == 5'd16);
            end
          end
        end
        ST_EMIT: begin
          if (take) begin
            first_pending_reg <= 1'b0;
            if (extra_pending_reg) begin
              // Stay in EMIT: the extra block is presented on the very next cycle.
              extra_pending_reg <= 1'b0;
              blk_first_reg     <= 1'b0;
              blk_last_reg      <= 1'b1;
            end else begin
              state_reg     <= ST_FILL;
              w_reg         <= 4'd0;
              in_ready_reg  <= 1'b1;
              blk_valid_reg <= 1'b0;
              blk_first_reg <= 1'b0;
              blk_last_reg  <= 1'b0;
              if (blk_last_reg) begin
                cnt_reg           <= '0;
                first_pending_reg <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign blk_valid = blk_valid_reg;
  assign blk_first = blk_first_reg;
  assign blk_last  = blk_last_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: padding boundaries, multi-block messages,
// backpressure hold and mid-message reset.
module tb_sha256_msg_padder;

  logic         Clk_tb = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;

  int total = 0;
  int bad   = 0;

  always #5 Clk_tb = ~Clk_tb;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .CLK       (Clk_tb),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  // Word i of the test pattern carries bytes 4i..4i+3.
  function automatic logic [31:0] pat(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n,
                           output logic ok);
    int waited;
    waited = 0;
    in_data = d; in_last = last; in_nbytes = n; in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge Clk_tb); #1;
      waited++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      @(posedge Clk_tb); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic f, output logic l,
                           output logic ok);
    int waited;
    waited = 0;
    while (blk_valid !== 1'b1 && waited < 50) begin
      @(posedge Clk_tb); #1;
      waited++;
    end
    ok = (blk_valid === 1'b1);
    d = blk_data; f = blk_first; l = blk_last;
    if (ok) begin
      blk_ready = 1'b1;
      @(posedge Clk_tb); #1;
      blk_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge Clk_tb);
    #1;
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", blk_valid); end
    total++; if (blk_first !== 1'b0) begin bad++; $display("FAIL reset_first: got %b want 0", blk_first); end
    total++; if (blk_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", blk_last); end
    total++; if (blk_data !== 512'h0) begin bad++; $display("FAIL reset_data: got %h want 0", blk_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    reset = 1'b0;
    @(posedge Clk_tb); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_abc();
    logic [511:0] d, exp;
    logic f, l, ok, okb;
    exp = {32'h61626380, 416'h0, 64'h18};
    send_word(32'h61626300, 1'b1, 3'd3, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL abc_send: got %b want 1", ok); end
    total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL abc_latency: got %b want 1", blk_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abc_in_ready_emit: got %b want 0", in_ready); end
    get_block(d, f, l, okb);
    total++; if (okb !== 1'b1) begin bad++; $display("FAIL abc_timeout: got %b want 1", okb); end
    total++; if (d !== exp) begin bad++; $display("FAIL abc_data: got %h want %h", d, exp); end
    total++; if ({f, l} !== 2'b11) begin bad++; $display("FAIL abc_flags: got %b want 11", {f, l}); end
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL abc_valid_drop: got %b want 0", blk_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abc_in_ready_back: got %b want 1", in_ready); end
    $display("test_abc: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_empty();
    logic [511:0] d, exp;
    logic f, l, ok, okb;
    exp = {32'h80000000, 480'h0};
    send_word(32'hDEADBEEF, 1'b1, 3'd0, ok);
    get_block(d, f, l, okb);
    total++; if ((ok & okb) !== 1'b1) begin bad++; $display("FAIL empty_handshake: got %b want 1", ok & okb); end
    total++; if (d !== exp) begin bad++; $display("FAIL empty_data: got %h want %h", d, exp); end
    total++; if ({f, l} !== 2'b11) begin bad++; $display("FAIL empty_flags: got %b want 11", {f, l}); end
    $display("test_empty: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_55();
    logic [511:0] d, exp;
    logic f, l, ok, okb, all_ok;
    all_ok = 1'b1;
    exp = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(pat(i), 1'b0, 3'd0, ok);
      all_ok &= ok;
      exp[511-32*i -: 32] = pat(i);
    end
    // Byte 55 of the input word must be replaced by the marker.
    send_word(pat(13), 1'b1, 3'd3, ok);
    all_ok &= ok;
    exp[511-32*13 -: 32] = 32'h34353680;
    exp[63:0] = 64'h1B8;
    get_block(d, f, l, okb);
    total++; if ((all_ok & okb) !== 1'b1) begin bad++; $display("FAIL b55_handshake: got %b want 1", all_ok & okb); end
    total++; if (d !== exp) begin bad++; $display("FAIL b55_data: got %h want %h", d, exp); end
    total++; if ({f, l} !== 2'b11) begin bad++; $display("FAIL b55_flags: got %b want 11", {f, l}); end
    $display("test_55: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_56();
    logic [511:0] d, exp1, exp2;
    logic f, l, ok, okb, all_ok;
    all_ok = 1'b1;
    exp1 = '0;
    for (int i = 0; i < 14; i++) begin
      send_word(pat(i), (i == 13), (i == 13) ? 3'd4 : 3'd0, ok);
      all_ok &= ok;
      exp1[511-32*i -: 32] = pat(i);
    end
    exp1[511-32*14 -: 32] = 32'h80000000;
    exp2 = {448'h0, 64'h1C0};
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp1) begin bad++; $display("FAIL b56_blk1_data: got %h want %h", d, exp1); end
    total++; if ({f, l} !== 2'b10) begin bad++; $display("FAIL b56_blk1_flags: got %b want 10", {f, l}); end
    total++; if (blk_valid !== 1'b1) begin bad++; $display("FAIL b56_no_bubble: got %b want 1", blk_valid); end
    $display("test_56 blk1: data=%h first=%b last=%b", d, f, l);
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp2) begin bad++; $display("FAIL b56_blk2_data: got %h want %h", d, exp2); end
    total++; if ({f, l} !== 2'b01) begin bad++; $display("FAIL b56_blk2_flags: got %b want 01", {f, l}); end
    total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL b56_handshake: got %b want 1", all_ok); end
    $display("test_56 blk2: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_64();
    logic [511:0] d, exp1, exp2;
    logic f, l, ok, okb, all_ok;
    all_ok = 1'b1;
    exp1 = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(pat(i), (i == 15), (i == 15) ? 3'd4 : 3'd0, ok);
      all_ok &= ok;
      exp1[511-32*i -: 32] = pat(i);
    end
    exp2 = {32'h80000000, 416'h0, 64'h200};
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp1) begin bad++; $display("FAIL b64_blk1_data: got %h want %h", d, exp1); end
    total++; if ({f, l} !== 2'b10) begin bad++; $display("FAIL b64_blk1_flags: got %b want 10", {f, l}); end
    $display("test_64 blk1: data=%h first=%b last=%b", d, f, l);
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp2) begin bad++; $display("FAIL b64_blk2_data: got %h want %h", d, exp2); end
    total++; if ({f, l} !== 2'b01) begin bad++; $display("FAIL b64_blk2_flags: got %b want 01", {f, l}); end
    total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL b64_handshake: got %b want 1", all_ok); end
    $display("test_64 blk2: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_backpressure();
    logic [511:0] d, exp;
    logic f, l, ok, okb, all_ok;
    // 5-byte message: length 40 bits, marker after byte 4.
    exp = {32'h11223344, 32'h55800000, 384'h0, 64'h28};
    send_word(32'h11223344, 1'b0, 3'd0, ok);
    all_ok = ok;
    send_word(32'h55AABBCC, 1'b1, 3'd1, ok);
    all_ok &= ok;
    in_data = 32'hCAFEF00D; in_last = 1'b1; in_nbytes = 3'd2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk_tb); #1;
      total++; if (blk_data !== exp) begin bad++; $display("FAIL bp_data_c%0d: got %h want %h", c, blk_data, exp); end
      total++; if ({blk_valid, blk_first, blk_last} !== 3'b111) begin bad++; $display("FAIL bp_flags_c%0d: got %b want 111", c, {blk_valid, blk_first, blk_last}); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", d, exp); end
    total++; if ({f, l} !== 2'b11) begin bad++; $display("FAIL bp_final_flags: got %b want 11", {f, l}); end
    total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL bp_handshake: got %b want 1", all_ok); end
    repeat (3) @(posedge Clk_tb);
    #1;
    total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL bp_no_ghost_block: got %b want 0", blk_valid); end
    $display("test_backpressure: data=%h first=%b last=%b", d, f, l);
  endtask

  task automatic test_reset_mid();
    logic [511:0] d, exp;
    logic f, l, ok, okb, all_ok;
    all_ok = 1'b1;
    exp = {32'h61626380, 416'h0, 64'h18};
    for (int i = 0; i < 7; i++) begin
      send_word(pat(i), 1'b0, 3'd0, ok);
      all_ok &= ok;
    end
    reset = 1'b1;
    @(posedge Clk_tb); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    reset = 1'b0;
    send_word(32'h61626300, 1'b1, 3'd3, ok);
    all_ok &= ok;
    get_block(d, f, l, okb);
    all_ok &= okb;
    total++; if (d !== exp) begin bad++; $display("FAIL rst_mid_data: got %h want %h", d, exp); end
    total++; if ({f, l} !== 2'b11) begin bad++; $display("FAIL rst_mid_flags: got %b want 11", {f, l}); end
    total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL rst_mid_handshake: got %b want 1", all_ok); end
    $display("test_reset_mid: data=%h first=%b last=%b", d, f, l);
  endtask

  initial begin
    reset = 1'b1; in_data = 32'h0; in_valid = 1'b0; in_last = 1'b0;
    in_nbytes = 3'd0; blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_55();
    test_56();
    test_64();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
